// File: rtl/actmem_stream_loader.sv
// Burst command bridge to the activation memory external port: write bursts from a
// valid/ready stream, read bursts returned through a 3-entry credit-managed skid FIFO.
module actmem_stream_loader #(
  parameter int unsigned WORDWIDTH        = 104,
  parameter int unsigned ADDRWIDTH        = 16,
  parameter int unsigned MEMWORDS         = 50176,
  parameter int unsigned BANKSETSBITWIDTH = 2,
  parameter int unsigned LENWIDTH         = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_write_i,
  input  logic [BANKSETSBITWIDTH-1:0] cmd_bank_set_i,
  input  logic [ADDRWIDTH-1:0]        cmd_addr_i,
  input  logic [LENWIDTH-1:0]         cmd_len_i,
  input  logic                        wdata_valid_i,
  output logic                        wdata_ready_o,
  input  logic [WORDWIDTH-1:0]        wdata_i,
  output logic                        rdata_valid_o,
  input  logic                        rdata_ready_i,
  output logic [WORDWIDTH-1:0]        rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDRWIDTH-1:0]        mem_addr_o,
  output logic [WORDWIDTH-1:0]        mem_wdata_o,
  output logic [BANKSETSBITWIDTH-1:0] mem_bank_set_o,
  input  logic [WORDWIDTH-1:0]        mem_rdata_i,
  input  logic                        mem_valid_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned FIFO_DEPTH = 3;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMWORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e                      state;
  logic [ADDRWIDTH-1:0]        addr_q;
  logic [LENWIDTH-1:0]         len_q;
  logic [BANKSETSBITWIDTH-1:0] bank_q;
  logic                        inflight;
  logic                        done_q;

  logic [WORDWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [1:0]           rd_ptr;
  logic [1:0]           wr_ptr;
  logic [1:0]           fifo_count;

  logic                 beat;
  logic                 issue;
  logic                 credit;
  logic                 push;
  logic                 pop;
  logic                 last;
  logic                 drain_done;
  logic [ADDRWIDTH-1:0] addr_next;

  // Credit counts the word already in flight so the FIFO can never overflow.
  assign credit     = (3'(fifo_count) + 3'(inflight)) < 3'(FIFO_DEPTH);
  assign beat       = (state == WRITE) && wdata_valid_i;
  assign issue      = (state == READ) && credit;
  assign push       = mem_valid_i && inflight;
  assign pop        = (fifo_count != 2'd0) && rdata_ready_i;
  assign last       = (len_q == LENWIDTH'(1));
  assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRWIDTH'(1);
  assign drain_done = !inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  assign cmd_ready_o    = (state == IDLE);
  assign busy_o         = (state != IDLE);
  assign wdata_ready_o  = (state == WRITE);
  assign done_o         = done_q;
  assign mem_req_o      = beat || issue;
  assign mem_we_o       = beat;
  assign mem_addr_o     = mem_req_o ? addr_q : '0;
  assign mem_wdata_o    = beat ? wdata_i : '0;
  assign mem_bank_set_o = busy_o ? bank_q : '0;
  assign rdata_valid_o  = (fifo_count != 2'd0);
  assign rdata_o        = rdata_valid_o ? fifo_mem[rd_ptr] : '0;

  // Burst sequencing: address/length bookkeeping and completion pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      bank_q   <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q <= cmd_addr_i;
            len_q  <= cmd_len_i;
            bank_q <= cmd_bank_set_i;
            if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= cmd_write_i ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (beat) begin
            addr_q <= addr_next;
            len_q  <= len_q - LENWIDTH'(1);
            if (last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= addr_next;
            len_q  <= len_q - LENWIDTH'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == 2'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == 2'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 2'd1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 2'd1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_actmem_stream_loader.sv
// Randomized bench for actmem_stream_loader: memory responder, word-level reference
// model of memory contents and burst expectations, one task per scenario.
module tb_actmem_stream_loader;

  localparam int unsigned WW = 104;
  localparam int unsigned AW = 16;
  localparam int unsigned MW = 50176;
  localparam int unsigned BW = 2;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [BW-1:0] cmd_bank_set;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [WW-1:0] wdata;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [WW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [BW-1:0] mem_bank_set;
  logic [WW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] ref_mem [int];
  logic [WW-1:0] env_mem [int];

  actmem_stream_loader dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_bank_set_i(cmd_bank_set), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_bank_set_o(mem_bank_set),
    .mem_rdata_i(mem_rdata), .mem_valid_i(mem_valid),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // External memory with fixed 1-cycle read latency.
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (mem_req === 1'b1) begin
      if (mem_we === 1'b1) begin
        env_mem[int'(mem_addr)] = mem_wdata;
      end else begin
        mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : '0;
        mem_valid <= 1'b1;
      end
    end
  end

  function automatic logic [WW-1:0] rand_word();
    return WW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Present a command at the current negedge; returns at the negedge after handshake.
  task automatic send_cmd(input logic wr, input int addr, input int len, input logic [BW-1:0] bs);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AW'(addr); cmd_len = LW'(len); cmd_bank_set = bs;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Write burst; gap_pct = chance of an idle wdata cycle; base_data < 0 = random words.
  task automatic run_write(input int addr, input int len, input logic [BW-1:0] bs,
                           input int gap_pct, input int base_data);
    int beats = 0;
    int cyc = 0;
    int a;
    logic [WW-1:0] d;
    send_cmd(1'b1, addr, len, bs);
    d = (base_data < 0) ? rand_word() : WW'(base_data);
    while (beats < len && cyc < 500) begin
      wdata_valid = ($urandom_range(99) >= gap_pct);
      wdata = d;
      #1;
      a = int'((addr + beats) % MW);
      total++;
      if (wdata_valid) begin
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(a) || mem_wdata !== d ||
            mem_bank_set !== bs || busy !== 1'b1 || wdata_ready !== 1'b1 || cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL wr_beat: req=%b we=%b addr=%0d data=%h bank=%0d busy=%b; want addr=%0d data=%h bank=%0d",
                   mem_req, mem_we, mem_addr, mem_wdata, mem_bank_set, busy, a, d, bs);
        end
        ref_mem[a] = d;
        beats++;
        d = (base_data < 0) ? rand_word() : WW'(base_data + beats);
      end else if (mem_req !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL wr_idle: req=%b busy=%b want req=0 busy=1", mem_req, busy);
      end
      @(negedge clk);
      cyc++;
    end
    wdata_valid = 1'b0;
    #1;
    total++;
    if (beats != len || done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        (gap_pct == 0 && cyc != len)) begin
      bad++;
      $display("FAIL wr_done: beats=%0d cyc=%0d done=%b busy=%b ready=%b; want beats=%0d done=1 busy=0 ready=1",
               beats, cyc, done, busy, cmd_ready, len);
    end
  endtask

  // Read burst; mode 0: ready=1, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_read(input int addr, input int len, input logic [BW-1:0] bs, input int mode);
    int issued = 0;
    int popped = 0;
    int cyc = 1;
    int outstanding;
    int a;
    bit finished = 0;
    send_cmd(1'b0, addr, len, bs);
    while (!finished && cyc < 600) begin
      rdata_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(1));
      #1;
      outstanding = issued - popped;
      if (mem_req === 1'b1) begin
        a = int'((addr + issued) % MW);
        total++;
        if (mem_we !== 1'b0 || issued >= len || outstanding >= 3 || mem_addr !== AW'(a) ||
            mem_bank_set !== bs) begin
          bad++;
          $display("FAIL rd_req: we=%b addr=%0d bank=%0d issued=%0d buffered=%0d; want addr=%0d bank=%0d buffered<3",
                   mem_we, mem_addr, mem_bank_set, issued, outstanding, a, bs);
        end
        issued++;
      end
      if (rdata_valid === 1'b1 && rdata_ready) begin
        a = int'((addr + popped) % MW);
        total++;
        if (popped >= len || rdata !== ref_mem[a] || (mode == 0 && cyc != 3 + popped)) begin
          bad++;
          $display("FAIL rd_data: word=%0d cyc=%0d got %h want %h", popped, cyc, rdata, ref_mem[a]);
        end
        popped++;
      end
      if (done === 1'b1) begin
        total++;
        if (popped != len || issued != len || rdata_valid !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL rd_done: popped=%0d issued=%0d valid=%b busy=%b want %0d words, valid=0 busy=0",
                   popped, issued, rdata_valid, busy, len);
        end
        finished = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    rdata_ready = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("FAIL rd_timeout: popped=%0d of %0d", popped, len);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (cmd_ready !== 1'b1 || wdata_ready !== 1'b0 || rdata_valid !== 1'b0 || mem_req !== 1'b0 ||
        mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata !== '0 || mem_addr !== '0 ||
        mem_wdata !== '0 || mem_bank_set !== '0) begin
      bad++;
      $display("FAIL %s: ready=%b wrdy=%b rvalid=%b req=%b we=%b busy=%b done=%b rdata=%h addr=%0d bank=%0d; want reset values",
               name, cmd_ready, wdata_ready, rdata_valid, mem_req, mem_we, busy, done, rdata, mem_addr, mem_bank_set);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank_set = '0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_idle_outputs("reset_values");
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    run_write(10, 4, 2'd1, 0, 10);
    @(negedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_done_width: done=%b busy=%b want 0 0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    run_read(10, 4, 2'd1, 0);
  endtask

  task automatic test_read_backpressure();
    run_write(100, 8, 2'd2, 30, -1);
    run_read(100, 8, 2'd2, 1);
  endtask

  task automatic test_wrap();
    run_write(int'(MW - 2), 3, 2'd3, 0, -1);
    run_read(int'(MW - 2), 3, 2'd3, 2);
  endtask

  task automatic test_len0();
    @(negedge clk);
    send_cmd(1'($urandom_range(1)), 77, 0, 2'd2);
    #1;
    total++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL len0_done: done=%b ready=%b busy=%b req=%b want 1 1 0 0", done, cmd_ready, busy, mem_req);
    end
    @(negedge clk);
    #1;
    total++;
    if (done !== 1'b0 || mem_req !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL len0_after: done=%b req=%b ready=%b want 0 0 1", done, mem_req, cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int a;
    int l;
    logic [BW-1:0] bs;
    for (int i = 0; i < 5; i++) begin
      a  = int'($urandom_range(MW - 1));
      l  = int'($urandom_range(6, 1));
      bs = BW'($urandom_range(3));
      run_write(a, l, bs, 25, -1);
      run_read(a, l, bs, 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    run_write(2000, 8, 2'd1, 0, -1);
    rdata_ready = 1'b0;
    send_cmd(1'b0, 2000, 8, 2'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    total++;
    if (rdata_valid !== 1'b1 || mem_req !== 1'b0 || rdata !== ref_mem[2000]) begin
      bad++;
      $display("FAIL pre_reset_full: valid=%b req=%b rdata=%h want valid=1 req=0 rdata=%h",
               rdata_valid, mem_req, rdata, ref_mem[2000]);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_idle_outputs("mid_read_reset");
    @(negedge clk);
    run_read(2000, 1, 2'd1, 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_backpressure();
    test_wrap();
    test_len0();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
